// File: rtl/weight_tile_scheduler.sv
// weight_tile_scheduler: walks (od-pair, id) tiles, handshaking weight_controller and the PE array
module weight_tile_scheduler #(
    parameter int OD_W = 8,
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_wen_i,
    input  logic [7:0]      total_id_i,
    input  logic [OD_W-1:0] total_od_i,
    input  logic            run_start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_err_o,
    output logic [OD_W-1:0] weight_od1_o,
    output logic [OD_W-1:0] weight_od2_o,
    output logic            od2_valid_o,
    output logic [ID_W-1:0] weight_id_o,
    output logic            weight_prepare_o,
    output logic            weight_start_o,
    input  logic            weight_ready_i,
    input  logic            pe_done_i
);
    typedef enum logic [2:0] {IDLE, PREP, WAIT_RDY, START, COMPUTE, ADV, DONE} state_t;
    localparam logic [ID_W:0] ID_MAX = (ID_W+1)'(2**ID_W);
    localparam logic [OD_W:0] OD_TWO = (OD_W+1)'(2);
    state_t state_q, state_d;
    logic [ID_W:0] cfg_id_q, cfg_id_d, run_id_q, run_id_d;
    logic [OD_W-1:0] cfg_od_q, cfg_od_d, run_od_q, run_od_d, od2_q, od2_d;
    logic [OD_W:0] od1_q, od1_d, od2_inc;
    logic [ID_W-1:0] id_q, id_d;
    logic cfg_err_q, cfg_err_d, od2v_q, od2v_d, busy_q, busy_d, done_q, done_d;
    logic prep_q, prep_d, start_q, start_d, id_ovf, id_last;
    assign id_ovf  = total_id_i > 8'(ID_MAX);
    assign id_last = ({1'b0, id_q} + 1'b1) == run_id_q;
    // Next-state, index stepping and registered-output computation
    always_comb begin
        state_d   = state_q;
        cfg_id_d  = cfg_id_q;
        cfg_od_d  = cfg_od_q;
        cfg_err_d = cfg_err_q;
        run_id_d  = run_id_q;
        run_od_d  = run_od_q;
        od1_d     = od1_q;
        id_d      = id_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        prep_d    = 1'b0;
        start_d   = 1'b0;
        if (state_q == IDLE && cfg_wen_i) begin
            cfg_id_d  = id_ovf ? ID_MAX : total_id_i[ID_W:0];
            cfg_od_d  = total_od_i;
            cfg_err_d = id_ovf;
        end
        case (state_q)
            IDLE: if (run_start_i) begin
                busy_d   = 1'b1;
                run_id_d = cfg_id_q;
                run_od_d = cfg_od_q;
                od1_d    = '0;
                id_d     = '0;
                state_d  = (cfg_id_q == '0 || cfg_od_q == '0) ? DONE : PREP;
            end
            PREP: begin
                prep_d  = 1'b1;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: state_d = weight_ready_i ? START : WAIT_RDY;
            START: begin
                start_d = 1'b1;
                state_d = COMPUTE;
            end
            COMPUTE: state_d = pe_done_i ? ADV : COMPUTE;
            ADV: begin
                id_d    = id_last ? '0 : id_q + 1'b1;
                od1_d   = id_last ? od1_q + OD_TWO : od1_q;
                state_d = (id_last && od1_q + OD_TWO >= {1'b0, run_od_q}) ? DONE : PREP;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        od2_inc = od1_d + 1'b1;
        od2v_d  = od2_inc < {1'b0, run_od_d};
        od2_d   = od2v_d ? od2_inc[OD_W-1:0] : od1_d[OD_W-1:0];
    end
    // State, configuration and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cfg_id_q  <= '0;
            cfg_od_q  <= '0;
            cfg_err_q <= 1'b0;
            run_id_q  <= '0;
            run_od_q  <= '0;
            od1_q     <= '0;
            od2_q     <= '0;
            od2v_q    <= 1'b0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prep_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_id_q  <= cfg_id_d;
            cfg_od_q  <= cfg_od_d;
            cfg_err_q <= cfg_err_d;
            run_id_q  <= run_id_d;
            run_od_q  <= run_od_d;
            od1_q     <= od1_d;
            od2_q     <= od2_d;
            od2v_q    <= od2v_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prep_q    <= prep_d;
            start_q   <= start_d;
        end
    end
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign cfg_err_o        = cfg_err_q;
    assign weight_od1_o     = od1_q[OD_W-1:0];
    assign weight_od2_o     = od2_q;
    assign od2_valid_o      = od2v_q;
    assign weight_id_o      = id_q;
    assign weight_prepare_o = prep_q;
    assign weight_start_o   = start_q;
endmodule
